// File: rtl/adc_frame_pkg.sv
// Shared types and constants for the ADC frame buffer: FSM state encodings,
// default ADC width and the mid-scale offset used for DC removal.
package adc_frame_pkg;

  localparam int          ADC_W_DEF = 12;
  localparam logic [11:0] MID_SCALE = 12'h800;

  typedef enum logic {W_FILL, W_WAIT}   wr_state_t;
  typedef enum logic {R_IDLE, R_STREAM} rd_state_t;

endpackage

// File: rtl/adc_frame_ram.sv
// Simple dual-port sample memory holding both ping-pong banks ({bank, ptr}
// addressing) with a one-cycle registered read port.
module adc_frame_ram #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/adc_frame_buffer.sv
// Ping-pong frame buffer: captures ADC samples into FRAME_LEN frames and streams
// them over valid/ready. Define ADC_FRAME_DC_REMOVE_EN for signed mid-scale removal.
module adc_frame_buffer
  import adc_frame_pkg::*;
#(
  parameter int FRAME_LEN = 256,
  parameter int ADC_W     = ADC_W_DEF,
  parameter int OUT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [ADC_W-1:0] adc_data_i,
  input  logic             adc_data_val_i,
  output logic [OUT_W-1:0] frm_data_o,
  output logic             frm_valid_o,
  input  logic             frm_ready_i,
  output logic             frm_sop_o,
  output logic             frm_eop_o,
  output logic             ovf_o
);

  localparam int              PTR_W = $clog2(FRAME_LEN);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(FRAME_LEN - 1);

`ifdef ADC_FRAME_DC_REMOVE_EN
  localparam logic [ADC_W-1:0] MID = (ADC_W == ADC_W_DEF) ? ADC_W'(MID_SCALE)
                                                           : {1'b1, {(ADC_W-1){1'b0}}};
`endif

  function automatic logic signed [OUT_W-1:0] to_out(input logic [ADC_W-1:0] s);
`ifdef ADC_FRAME_DC_REMOVE_EN
    logic signed [ADC_W-1:0] d;
    d = signed'(s - MID);
    return signed'({{(OUT_W-ADC_W){d[ADC_W-1]}}, d});
`else
    return signed'({{(OUT_W-ADC_W){1'b0}}, s});
`endif
  endfunction

  wr_state_t        wr_state, wr_state_nxt;
  logic [PTR_W-1:0] wr_ptr;
  logic             wr_bank, wr_en, set_full, wr_toggle, other_busy;
  logic [1:0]       full;

  rd_state_t        rd_state, rd_state_nxt;
  logic [PTR_W-1:0] rd_ptr;
  logic             rd_bank, rd_all, rd_en;

  logic [ADC_W-1:0]        ram_q_p1, skid_q_p2;
  logic                    vld_p1, sop_p1, eop_p1;
  logic                    skid_vld_p2, skid_sop_p2, skid_eop_p2;
  logic signed [OUT_W-1:0] data_p2;
  logic                    vld_p2, sop_p2, eop_p2;
  logic                    accept, eop_acc, load_out;
  logic [1:0]              occ;

  assign accept   = vld_p2 && frm_ready_i;
  assign eop_acc  = accept && eop_p2;
  assign load_out = !vld_p2 || frm_ready_i;
  // Beats held or in flight after this cycle; a new read needs a free slot.
  assign occ = {1'b0, vld_p2} + {1'b0, skid_vld_p2} + {1'b0, vld_p1} - {1'b0, accept};

  always_comb begin
    wr_state_nxt = wr_state;
    wr_en        = 1'b0;
    set_full     = 1'b0;
    wr_toggle    = 1'b0;
    ovf_o        = 1'b0;
    // A bank released by this cycle's eop handshake already counts as free.
    other_busy   = full[~wr_bank] && !(eop_acc && (rd_bank != wr_bank));
    case (wr_state)
      W_FILL: if (adc_data_val_i) begin
        wr_en = 1'b1;
        if (wr_ptr == LAST) begin
          set_full = 1'b1;
          if (other_busy) wr_state_nxt = W_WAIT;
          else            wr_toggle    = 1'b1;
        end
      end
      W_WAIT: begin
        ovf_o = adc_data_val_i;
        if (!full[~wr_bank]) begin
          wr_toggle    = 1'b1;
          wr_state_nxt = W_FILL;
        end
      end
      default: wr_state_nxt = W_FILL;
    endcase
  end

  always_comb begin
    rd_state_nxt = rd_state;
    rd_en        = 1'b0;
    case (rd_state)
      R_IDLE: if (full[rd_bank]) begin
        rd_en        = 1'b1;
        rd_state_nxt = R_STREAM;
      end
      R_STREAM: begin
        rd_en = !rd_all && (occ < 2'd2);
        if (eop_acc) rd_state_nxt = R_IDLE;
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  adc_frame_ram #(.DATA_W(ADC_W), .ADDR_W(PTR_W + 1)) u_ram (
    .clk     (clk_i),
    .wr_en   (wr_en),
    .wr_addr ({wr_bank, wr_ptr}),
    .wr_data (adc_data_i),
    .rd_en   (rd_en),
    .rd_addr ({rd_bank, rd_ptr}),
    .rd_data (ram_q_p1)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_state    <= W_FILL;
      wr_ptr      <= '0;
      wr_bank     <= 1'b0;
      full        <= 2'b00;
      rd_state    <= R_IDLE;
      rd_ptr      <= '0;
      rd_bank     <= 1'b0;
      rd_all      <= 1'b0;
      vld_p1      <= 1'b0;
      sop_p1      <= 1'b0;
      eop_p1      <= 1'b0;
      skid_vld_p2 <= 1'b0;
      vld_p2      <= 1'b0;
      sop_p2      <= 1'b0;
      eop_p2      <= 1'b0;
      data_p2     <= '0;
    end else begin
      wr_state <= wr_state_nxt;
      if (wr_en)     wr_ptr  <= wr_ptr + 1'b1;
      if (wr_toggle) wr_bank <= ~wr_bank;
      if (set_full)  full[wr_bank] <= 1'b1;
      if (eop_acc)   full[rd_bank] <= 1'b0;

      rd_state <= rd_state_nxt;
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (rd_ptr == LAST) rd_all <= 1'b1;
      end
      if (eop_acc) begin
        rd_all  <= 1'b0;
        rd_bank <= ~rd_bank;
      end

      // p1: RAM read data returns, tagged with frame position
      vld_p1 <= rd_en;
      if (rd_en) begin
        sop_p1 <= (rd_ptr == '0);
        eop_p1 <= (rd_ptr == LAST);
      end

      // p2: output register fed from the skid entry first, then the RAM
      if (load_out) begin
        vld_p2 <= skid_vld_p2 || vld_p1;
        if (skid_vld_p2) begin
          data_p2     <= to_out(skid_q_p2);
          sop_p2      <= skid_sop_p2;
          eop_p2      <= skid_eop_p2;
          skid_vld_p2 <= vld_p1;
        end else if (vld_p1) begin
          data_p2 <= to_out(ram_q_p1);
          sop_p2  <= sop_p1;
          eop_p2  <= eop_p1;
        end
      end else if (vld_p1) begin
        skid_vld_p2 <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (vld_p1 && (!load_out || skid_vld_p2)) begin
      skid_q_p2   <= ram_q_p1;
      skid_sop_p2 <= sop_p1;
      skid_eop_p2 <= eop_p1;
    end
  end

  assign frm_data_o  = data_p2;
  assign frm_valid_o = vld_p2;
  assign frm_sop_o   = sop_p2;
  assign frm_eop_o   = eop_p2;

endmodule

// File: tb/tb_adc_frame_buffer.sv
// Scoreboard bench for adc_frame_buffer with FRAME_LEN = 8; expectations follow
// ADC_FRAME_DC_REMOVE_EN the same way the design build does.
module tb_adc_frame_buffer;

  typedef struct packed {
    logic [15:0] d;
    logic        s;
    logic        e;
  } beat_t;

  logic        clk, rst;
  logic [11:0] adc_data;
  logic        adc_val;
  logic [15:0] frm_data;
  logic        frm_valid, frm_ready, frm_sop, frm_eop, ovf;

  int    cyc = 0;
  int    n_chk = 0;
  int    n_fail = 0;
  int    ovf_cnt = 0;
  int    rise_cyc = -1;
  int    last_strobe_cyc = 0;
  logic  rdy_mode = 1'b0;
  beat_t q[$];

  adc_frame_buffer #(.FRAME_LEN(8), .ADC_W(12), .OUT_W(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .adc_data_i     (adc_data),
    .adc_data_val_i (adc_val),
    .frm_data_o     (frm_data),
    .frm_valid_o    (frm_valid),
    .frm_ready_i    (frm_ready),
    .frm_sop_o      (frm_sop),
    .frm_eop_o      (frm_eop),
    .ovf_o          (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] exp_val(input logic [11:0] s);
`ifdef ADC_FRAME_DC_REMOVE_EN
    exp_val = {4'h0, s} - 16'h0800;
`else
    exp_val = {4'h0, s};
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_beat(input logic [11:0] v, input logic s, input logic e);
    beat_t b;
    b.d = exp_val(v);
    b.s = s;
    b.e = e;
    q.push_back(b);
  endtask

  task automatic push_ramp(input int base);
    for (int i = 0; i < 8; i++) push_beat(12'(base + i), i == 0, i == 7);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [11:0] v);
    adc_data        = v;
    adc_val         = 1'b1;
    last_strobe_cyc = cyc;
    @(posedge clk);
    #1;
    adc_val = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while (q.size() != 0 && n < max_cyc) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_queue_empty", q.size(), 0);
    idle(4);
  endtask

  // Monitor: scoreboard pops on each handshake, stall stability, ovf timing
  initial begin
    logic        p_valid, p_ready, p_sop, p_eop;
    logic [15:0] p_data;
    beat_t       e;
    p_valid = 1'b0;
    p_ready = 1'b0;
    p_sop   = 1'b0;
    p_eop   = 1'b0;
    p_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_valid = 1'b0;
      end else begin
        if (frm_valid && frm_ready) begin
          n_chk++;
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_beat: got data %0h sop %0b eop %0b, expected no beat",
                     frm_data, frm_sop, frm_eop);
          end else begin
            e = q.pop_front();
            if ({frm_data, frm_sop, frm_eop} !== {e.d, e.s, e.e}) begin
              n_fail++;
              $display("FAIL beat: got data %0h sop %0b eop %0b, expected data %0h sop %0b eop %0b",
                       frm_data, frm_sop, frm_eop, e.d, e.s, e.e);
            end
          end
        end
        if (p_valid && !p_ready)
          check("stall_stable", {frm_valid, frm_data, frm_sop, frm_eop},
                {1'b1, p_data, p_sop, p_eop});
        if (ovf) begin
          ovf_cnt++;
          check("ovf_with_strobe", adc_val, 1'b1);
        end
        if (frm_valid && !p_valid && rise_cyc < 0) rise_cyc = cyc;
        p_valid = frm_valid;
        p_ready = frm_ready;
        p_sop   = frm_sop;
        p_eop   = frm_eop;
        p_data  = frm_data;
      end
    end
  end

  // Fixed 50% duty irregular ready pattern
  initial begin
    logic [15:0] rdy_pat;
    int          pidx;
    rdy_pat = 16'b1011_0010_0110_1001;
    pidx    = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode) begin
        frm_ready = rdy_pat[pidx];
        pidx      = (pidx + 1) % 16;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] xv [8];
    int          ovf_base;
    xv = '{12'h000, 12'hFFF, 12'h800, 12'h7FF, 12'h001, 12'hFFE, 12'h123, 12'hABC};
    rst       = 1'b1;
    adc_val   = 1'b0;
    adc_data  = '0;
    frm_ready = 1'b0;
    idle(3);
    check("reset_valid", frm_valid, 1'b0);
    check("reset_sop",   frm_sop,   1'b0);
    check("reset_eop",   frm_eop,   1'b0);
    check("reset_ovf",   ovf,       1'b0);
    check("reset_data",  frm_data,  16'h0000);
    rst = 1'b0;
    idle(2);

    // Ramp 0..7 with ready high; first beat 3 cycles after the last strobe
    frm_ready = 1'b1;
    rise_cyc  = -1;
    push_ramp(0);
    for (int i = 0; i < 8; i++) send(12'(i));
    wait_drain(100);
    check("latency_last_strobe_to_valid", 32'(rise_cyc - last_strobe_cyc), 32'd3);

    // Conversion extremes
    for (int i = 0; i < 8; i++) push_beat(xv[i], i == 0, i == 7);
    for (int i = 0; i < 8; i++) send(xv[i]);
    wait_drain(100);

    // Four ramp frames against an irregular ready
    ovf_base = ovf_cnt;
    rdy_mode = 1'b1;
    for (int f = 0; f < 4; f++) push_ramp(16 + 8 * f);
    for (int i = 0; i < 32; i++) begin
      send(12'(16 + i));
      idle(3);
    end
    wait_drain(600);
    rdy_mode  = 1'b0;
    frm_ready = 1'b1;
    check("ovf_during_random_ready", 32'(ovf_cnt - ovf_base), 32'd0);

    // Ready low for 19 strobes: two frames held, three drops
    frm_ready = 1'b0;
    idle(1);
    ovf_base = ovf_cnt;
    push_ramp(0);
    push_ramp(8);
    for (int i = 0; i < 19; i++) send(12'(i));
    idle(3);
    check("ovf_pulses_both_full", 32'(ovf_cnt - ovf_base), 32'd3);
    check("held_first_beat", {frm_valid, frm_sop, frm_data}, {1'b1, 1'b1, exp_val(12'd0)});
    frm_ready = 1'b1;
    idle(40);
    push_ramp(20);
    for (int i = 20; i < 28; i++) send(12'(i));
    wait_drain(200);
    check("ovf_after_release", 32'(ovf_cnt - ovf_base), 32'd3);

    // Frame completes in the same cycle as the other bank's eop handshake
    ovf_base = ovf_cnt;
    push_ramp(40);
    push_ramp(48);
    push_ramp(56);
    for (int i = 40; i < 48; i++) send(12'(i));
    idle(2);
    for (int i = 48; i < 64; i++) send(12'(i));
    wait_drain(200);
    check("ovf_simultaneous_free", 32'(ovf_cnt - ovf_base), 32'd0);

    // Partial frame discarded by reset
    ovf_base = ovf_cnt;
    for (int i = 1; i <= 5; i++) send(12'(i));
    idle(3);
    check("partial_no_output", frm_valid, 1'b0);
    rst = 1'b1;
    idle(2);
    check("midreset_valid", frm_valid, 1'b0);
    check("midreset_data",  frm_data,  16'h0000);
    rst = 1'b0;
    idle(2);
    push_ramp(100);
    for (int i = 100; i < 108; i++) send(12'(i));
    wait_drain(100);
    idle(10);
    check("no_extra_frame_after_reset", frm_valid, 1'b0);
    check("ovf_after_reset", 32'(ovf_cnt - ovf_base), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_frame_buffer.md
# adc_frame_buffer

Downstream of the ADC resampler: collects decimated 12-bit ADC samples into fixed-length frames and streams each complete frame to the spectrum/visualizer datapath over a valid/ready interface. Double-buffered (ping-pong), so capture continues while the previous frame drains. Converts samples to signed two's complement and flags samples dropped when both banks are occupied.

## Interface
- `FRAME_LEN`, 256: samples per frame; power of two, at least 4.
- `ADC_W`, 12: input sample width.
- `OUT_W`, 16: output sample width; must exceed `ADC_W`.
- `clk_i`  in  1: single clock for the whole block.
- `rst_i`  in  1: asynchronous, active-high reset.
- `adc_data_i`  in  ADC_W: unsigned sample from the resampler.
- `adc_data_val_i`  in  1: one-cycle strobe; `adc_data_i` is valid in that cycle.
- `frm_data_o`  out  OUT_W: output sample.
- `frm_valid_o`  out  1: `frm_data_o`, `frm_sop_o` and `frm_eop_o` are valid.
- `frm_ready_i`  in  1: sink accepts the beat in any cycle where `frm_valid_o && frm_ready_i`.
- `frm_sop_o`  out  1: first sample of a frame.
- `frm_eop_o`  out  1: last sample of a frame.
- `ovf_o`  out  1: one-cycle pulse for each input sample dropped.

## Operation
- Two banks, each `FRAME_LEN` deep, each with a `full` flag.
- Write side FSM: `W_FILL`, `W_WAIT`.
  - `W_FILL`: each `adc_data_val_i` writes to `wr_bank[wr_ptr]`, then increments `wr_ptr`. `wr_ptr` has width $clog2(FRAME_LEN) and wraps to 0.
  - When the write at `wr_ptr == FRAME_LEN-1` completes, `full[wr_bank]` is set.
    - If the other bank is not full, `wr_bank` toggles and the FSM stays in `W_FILL`.
    - Otherwise the FSM goes to `W_WAIT`.
  - `W_WAIT`: every `adc_data_val_i` is discarded and pulses `ovf_o`. When the other bank's `full` clears, `wr_bank` toggles and the FSM returns to `W_FILL` with `wr_ptr = 0`. Frames therefore always hold contiguous samples.
- Read side FSM: `R_IDLE`, `R_STREAM`.
  - `R_IDLE`: when `full[rd_bank]` is set, go to `R_STREAM` and issue RAM read at address 0.
  - `R_STREAM`: stream `FRAME_LEN` beats in address order.
    - Output register plus a one-entry skid buffer gives full throughput (1 beat/cycle) while `frm_ready_i` is held high.
    - While `frm_valid_o && !frm_ready_i`, all outputs are held stable.
  - On the `frm_eop_o` handshake: clear `full[rd_bank]`, toggle `rd_bank`, go to `R_IDLE`.
- Sample conversion: `frm_data_o = sign_extend(adc_data_i - MID_SCALE)`. `MID_SCALE` is 2048 for `ADC_W` = 12.
- Simultaneous events:
  - A bank freed by the `frm_eop_o` handshake in the same cycle the write side completes a frame counts as free. No `W_WAIT`, no overflow.
  - A sample arriving in the cycle `W_WAIT` exits is still dropped. Capture starts with the next strobe.
- Reset mid-operation: any partial frame and any queued frame are discarded. Both FSMs return to their idle/fill state.

## Timing
- Values after reset:
  - `frm_valid_o`, `frm_sop_o`, `frm_eop_o`, `ovf_o` = 0; `frm_data_o` = 0.
  - `wr_ptr` = 0; `wr_bank` = `rd_bank` = 0; both `full` = 0.
- Latency: last-sample strobe in cycle N → `full` set in N+1 → RAM read issued in N+1 → RAM data in N+2 → `frm_valid_o` with `frm_sop_o` in N+3.
- RAM read latency is 1 cycle.
- `ovf_o` asserts in the same cycle as the dropped strobe.
- With `frm_ready_i` held high, a frame drains in `FRAME_LEN` consecutive cycles.

## Configuration
- `ADC_FRAME_DC_REMOVE_EN` defined: mid-scale subtraction and sign extension, as described above.
- Not defined: `frm_data_o` is `adc_data_i` zero-extended to `OUT_W` (raw unsigned); no subtractor is built.

## Structure
- Package `adc_frame_pkg`:
  - `ADC_W_DEF`, `MID_SCALE` (12'h800)
  - `wr_state_t` (`W_FILL`, `W_WAIT`)
  - `rd_state_t` (`R_IDLE`, `R_STREAM`)
- Sub-module `adc_frame_ram`: simple dual-port memory, depth 2×`FRAME_LEN`, 1-cycle registered read. Address is {bank, ptr}.

## Test plan
All scenarios use `FRAME_LEN` = 8.
- DC enabled, ramp 0..7, ready held high → beats -2048..-2041 (16'hF800..16'hF807). `sop` on beat 1, `eop` on beat 8. `frm_valid_o` rises exactly 3 cycles after the 8th strobe.
- Random `frm_ready_i` (50%) over 4 frames of ramp → every beat matches input order; outputs are stable whenever valid is high and ready is low.
- `frm_ready_i` low for 19 strobes → frames 0–7 and 8–15 are held; strobes 16–18 each pulse `ovf_o` (3 pulses). After ready rises, the 3rd frame begins with the first strobe after bank 0 frees.
- Write side completes a frame in the same cycle the read side's `eop` handshakes → no `ovf_o`; the next strobe lands at index 0 of the freed bank.
- 5 strobes, then `rst_i` pulse, then strobes 100..107 → exactly one frame, containing 100..107. No output before reset is released.
- Macro undefined, input 12'hFFF → `frm_data_o` = 16'h0FFF.
